bin_excess3: RTL and testbench

- Registered binary-to-excess-3 code converter: y = a + 3.
- Takes a 4-bit unsigned binary value and produces a 5-bit result, so every 4-bit input, including 10..15, converts without overflow.
- Also flags inputs outside the BCD digit range 0..9.
- Sits in the datapath between a binary source and excess-3 consumers such as display or serial coding logic.

---
 rtl/bin_excess3.sv | 30 +++
 tb/tb_bin_excess3.sv | 94 +++++++++
 2 files changed

// File: rtl/bin_excess3.sv
// bin_excess3: registered binary-to-excess-3 converter (y = a + BIAS) with out-of-BCD-range flag
module bin_excess3 #(
  parameter int IN_W    = 4,
  parameter int BIAS    = 3,
  parameter int BCD_MAX = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] a,
  output logic            out_valid,
  output logic [IN_W:0]   y,
  output logic            err
);
  localparam logic [IN_W:0]   BIAS_W = (IN_W+1)'(BIAS);
  localparam logic [IN_W-1:0] MAX_W  = IN_W'(BCD_MAX);
  // The extra result bit holds the carry, so a + BIAS never wraps.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y   <= {1'b0, a} + BIAS_W;
        err <= a > MAX_W;
      end
    end
endmodule

// File: tb/tb_bin_excess3.sv
// tb_bin_excess3: directed and random checks of bin_excess3 against an arithmetic reference model
module tb_bin_excess3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'd0;
  logic       out_valid;
  logic [4:0] y;
  logic       err;

  int vecs = 0;
  int errs = 0;
  int m_y = 0, m_err = 0, m_ov = 0;

  bin_excess3 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .out_valid(out_valid), .y(y), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".y"}, 32'(y), 32'(m_y));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
  endtask

  // Drive away from the edge, let the edge capture, then compare with the model.
  task automatic step(input logic v, input logic [3:0] av, input string tag);
    @(negedge clk);
    in_valid = v;
    a = av;
    @(posedge clk);
    if (rst_n) begin
      m_ov = int'(v);
      if (v) begin
        m_y = int'(av) + 3;
        m_err = (int'(av) > 9) ? 1 : 0;
      end
    end else begin
      m_ov = 0; m_y = 0; m_err = 0;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    chk_all("reset_initial");
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step(1'b1, 4'(i), "seq_digits");

    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), "sweep");
    chk("sweep_max_y", 32'(y), 32'd18);

    step(1'b1, 4'd9, "hold_load");
    for (int i = 0; i < 3; i++) step(1'b0, 4'd5, "hold");
    chk("hold_y12", 32'(y), 32'd12);

    step(1'b1, 4'd2, "bubble0");
    step(1'b0, 4'd7, "bubble1");
    step(1'b1, 4'd8, "bubble2");
    chk("bubble_y11", 32'(y), 32'd11);

    for (int i = 0; i < 3; i++) step(1'b1, 4'd6, "stream6");
    rst_n = 1'b0;
    m_y = 0; m_err = 0; m_ov = 0;
    #2;
    chk_all("async_reset");
    step(1'b1, 4'd6, "reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd1, "post_release");
    chk("post_release_y4", 32'(y), 32'd4);

    for (int i = 0; i < 60; i++)
      step(($urandom % 4) != 0, 4'($urandom), "random");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
